// File: rtl/fp_mul_result_stage.sv
// Registered result stage for a combinational fp multiplier: classifies each result,
// derives IEEE-754 exception flags, accumulates sticky flags and buffers entries in an in-order FIFO.
module fp_mul_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_num1,
    input  logic [31:0]      in_num2,
    input  logic [31:0]      in_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [2:0]       out_class,
    output logic [2:0]       out_flags,
    output logic [2:0]       sticky_flags,
    input  logic             flags_clr,
    output logic [CNT_W-1:0] result_count
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready depends on registered FIFO state only, never on out_ready.

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 38;

    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_SUB  = 3'd1;
    localparam logic [2:0] CLS_NORM = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_QNAN = 3'd4;
    localparam logic [2:0] CLS_SNAN = 3'd5;

    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [AW-1:0]    IDX_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    function automatic logic [2:0] fp_class(input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] f;
        e = v[30:23];
        f = v[22:0];
        if (e == 8'h00)      fp_class = (f == 23'd0) ? CLS_ZERO : CLS_SUB;
        else if (e == 8'hFF) begin
            if (f == 23'd0)  fp_class = CLS_INF;
            else if (f[22])  fp_class = CLS_QNAN;
            else             fp_class = CLS_SNAN;
        end
        else                 fp_class = CLS_NORM;
    endfunction

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [2:0] cls_a;
    logic [2:0] cls_b;
    logic [2:0] cls_r;
    logic       fin_a;
    logic       fin_b;
    logic       nz_a;
    logic       nz_b;
    logic       flag_inv;
    logic       flag_ovf;
    logic       flag_unf;
    logic [2:0] new_flags;
    logic [AW-1:0] head_idx;
    logic [EW-1:0] head;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign cls_a = fp_class(in_num1);
    assign cls_b = fp_class(in_num2);
    assign cls_r = fp_class(in_result);

    // Finite here means zero, subnormal or normal; infinities and NaNs are excluded.
    assign fin_a = (cls_a == CLS_ZERO) || (cls_a == CLS_SUB) || (cls_a == CLS_NORM);
    assign fin_b = (cls_b == CLS_ZERO) || (cls_b == CLS_SUB) || (cls_b == CLS_NORM);
    assign nz_a  = (cls_a == CLS_SUB) || (cls_a == CLS_NORM);
    assign nz_b  = (cls_b == CLS_SUB) || (cls_b == CLS_NORM);

    assign flag_inv = (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN) ||
                      ((cls_a == CLS_ZERO) && (cls_b == CLS_INF)) ||
                      ((cls_a == CLS_INF) && (cls_b == CLS_ZERO));
    assign flag_ovf = fin_a && fin_b && (cls_r == CLS_INF);
    assign flag_unf = nz_a && nz_b && ((cls_r == CLS_ZERO) || (cls_r == CLS_SUB));
    assign new_flags = {flag_inv, flag_ovf, flag_unf};

    // When empty, the slot behind the read pointer holds the last popped entry (zero after reset).
    assign head_idx = empty ? (rd_ptr[AW-1:0] - IDX_ONE) : rd_ptr[AW-1:0];
    assign head     = mem[head_idx];

    assign out_result = head[37:6];
    assign out_class  = head[5:3];
    assign out_flags  = head[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {in_result, cls_r, new_flags};
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // A flag raised by a push in the same cycle as a clear survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
            result_count <= '0;
        end else begin
            sticky_flags <= (flags_clr ? 3'b000 : sticky_flags) | (push ? new_flags : 3'b000);
            if (push) begin
                result_count <= result_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_result_stage.sv
// Directed bench for fp_mul_result_stage: stimulus pushes expected head entries into a queue,
// a monitor pops and compares them whenever the stage delivers an output.
module tb_fp_mul_result_stage;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_num1;
  logic [31:0] in_num2;
  logic [31:0] in_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_class;
  logic [2:0]  out_flags;
  logic [2:0]  sticky_flags;
  logic        flags_clr;
  logic [15:0] result_count;

  logic [37:0] exp_q[$];
  int          total;
  int          bad;
  logic [15:0] exp_count;

  fp_mul_result_stage #(.DEPTH(2), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_num1      (in_num1),
    .in_num2      (in_num2),
    .in_result    (in_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_class    (out_class),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .flags_clr    (flags_clr),
    .result_count (result_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // driver: hold inputs until accepted, record the expected head entry
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                      input logic [2:0] cls, input logic [2:0] flg);
    int n;
    in_valid  = 1'b1;
    in_num1   = a;
    in_num2   = b;
    in_result = r;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 64'(in_ready), 64'd1);
    end else begin
      exp_q.push_back({r, cls, flg});
      exp_count++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    flags_clr = 1'b1;
    @(posedge clk);
    #1;
    flags_clr = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    logic [37:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {26'd0, out_result, out_class, out_flags}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("head_entry", {26'd0, out_result, out_class, out_flags}, {26'd0, e});
        end
      end
    end
  end

  initial begin
    total     = 0;
    bad       = 0;
    exp_count = 16'd0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_num1   = 32'd0;
    in_num2   = 32'd0;
    in_result = 32'd0;
    out_ready = 1'b1;
    flags_clr = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_class", 64'(out_class), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_sticky", 64'(sticky_flags), 64'd0);
    check("rst_count", 64'(result_count), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // T1 normal result, visible the cycle after acceptance
    send(32'h3FE87CF5, 32'h3F0CF1E1, 32'h3F800000, 3'd2, 3'b000);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_count", 64'(result_count), 64'd1);
    drain();

    // T2 invalid: zero*inf and sNaN operand
    send(32'h00000000, 32'h7F800000, 32'h7FC00000, 3'd4, 3'b100);
    check("t2_sticky", 64'(sticky_flags), 64'h4);
    send(32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'd4, 3'b100);
    drain();
    pulse_clear();
    check("clr_no_push", 64'(sticky_flags), 64'h0);

    // T3 overflow, underflow, subnormal result, propagated sNaN result
    send(32'h7F000000, 32'h7F000000, 32'h7F800000, 3'd3, 3'b010);
    check("t3_sticky_ovf", 64'(sticky_flags), 64'h2);
    send(32'h00800000, 32'h00800000, 32'h00000000, 3'd0, 3'b001);
    check("t3_sticky_both", 64'(sticky_flags), 64'h3);
    send(32'h00400000, 32'h3F800000, 32'h00400000, 3'd1, 3'b001);
    send(32'h7FA00000, 32'h3F800000, 32'h7FA00000, 3'd5, 3'b100);
    check("t3_sticky_all", 64'(sticky_flags), 64'h7);
    drain();
    check("count_mid", 64'(result_count), 64'(exp_count));

    // T5 clear racing a push of an overflow result: the set wins
    flags_clr = 1'b1;
    send(32'h7F000000, 32'h40000000, 32'h7F800000, 3'd3, 3'b010);
    flags_clr = 1'b0;
    check("t5_race", 64'(sticky_flags), 64'h2);
    pulse_clear();
    check("t5_clear", 64'(sticky_flags), 64'h0);
    drain();
    check("empty_out_valid", 64'(out_valid), 64'd0);

    // T4 backpressure: two accepted, third held until the consumer drains
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 32'h40000000, 3'd2, 3'b000);
    send(32'h40000000, 32'h40400000, 32'h40C00000, 3'd2, 3'b000);
    fork
      send(32'h40400000, 32'h40800000, 32'h41400000, 3'd2, 3'b000);
      begin
        @(negedge clk);
        check("t4_in_ready_full", 64'(in_ready), 64'd0);
        check("t4_count_held", 64'(result_count), 64'(exp_count));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("t4_count", 64'(result_count), 64'(exp_count));

    // T6 asynchronous reset with two entries queued
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'd2, 3'b000);
    send(32'h00000000, 32'h7F800000, 32'h7FC00000, 3'd4, 3'b100);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_sticky", 64'(sticky_flags), 64'd0);
    check("t6_count", 64'(result_count), 64'd0);
    exp_q.delete();
    exp_count = 16'd0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(32'h40A00000, 32'h40000000, 32'h41200000, 3'd2, 3'b000);
    check("t6_new_valid", 64'(out_valid), 64'd1);
    drain();
    check("t6_count_after", 64'(result_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
